// File: rtl/assembler_sequencer.sv
// Two-pass assembler sequencer: streams line-organised text from BRAM into the
// assembler core, once for label collection and once for encoding, and stores each word.
package assembler_pkg;
  typedef enum logic [1:0] {
    IDLE                = 2'd0,
    PC_MAPPING          = 2'd1,
    INSTRUCTION_MAPPING = 2'd2
  } assembler_state_t;
endpackage

module assembler_sequencer
  import assembler_pkg::*;
#(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUMBER_LINES  = 256,
  parameter int BRAM_LATENCY  = 2,
  parameter int CHAR_GAP      = 2,
  parameter int DONE_TIMEOUT  = 16
) (
  input  logic                                             clk_in,
  input  logic                                             rst_in,
  input  logic                                             start,
  input  logic [$clog2(NUMBER_LINES):0]                    num_lines,
  output logic [$clog2(NUMBER_LINES*CHAR_PER_LINE)-1:0]    text_addr,
  input  logic [7:0]                                       text_data,
  output logic                                             new_line,
  output logic                                             new_character,
  output logic [$clog2(NUMBER_LINES)-1:0]                  line_count,
  output logic [$clog2(CHAR_PER_LINE)-1:0]                 char_count,
  output logic [7:0]                                       incoming_character,
  output assembler_state_t                                 assembler_state,
  input  logic                                             core_done,
  input  logic                                             core_error,
  input  logic [31:0]                                      core_instruction,
  output logic                                             imem_we,
  output logic [$clog2(NUMBER_LINES)-1:0]                  imem_addr,
  output logic [31:0]                                      imem_data,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             error,
  output logic [$clog2(NUMBER_LINES)-1:0]                  error_line
);
  localparam int LW   = $clog2(NUMBER_LINES);
  localparam int NW   = LW + 1;
  localparam int AW   = $clog2(NUMBER_LINES * CHAR_PER_LINE);
  localparam int CW   = $clog2(CHAR_PER_LINE);
  localparam int T1   = (DONE_TIMEOUT > BRAM_LATENCY) ? DONE_TIMEOUT : BRAM_LATENCY;
  localparam int TMAX = (T1 > CHAR_GAP) ? T1 : CHAR_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LINE_START, S_FETCH, S_WAIT_RD, S_EMIT, S_GAP, S_LINE_END,
    S_WAIT_DONE, S_WRITE, S_PASS_SWITCH, S_FINISH, S_FAIL
  } state_t;

  state_t           state_q;
  logic             pass2_q;
  logic [LW-1:0]    line_q;
  logic [CW-1:0]    char_q;
  logic [CW-1:0]    char_cnt_q;
  logic [TW-1:0]    wait_q;
  logic [NW-1:0]    num_lines_q;
  logic [LW-1:0]    inst_ptr_q;
  logic             full_q;
  logic [31:0]      inst_q;
  logic             new_line_q;
  logic             new_char_q;
  logic [7:0]       inc_char_q;
  assembler_state_t asm_q;
  logic             imem_we_q;
  logic [LW-1:0]    imem_addr_q;
  logic [31:0]      imem_data_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [LW-1:0]    error_line_q;

  logic             last_line_d;
  logic [LW-1:0]    adv_line_d;
  state_t           adv_state_d;
  logic             term_d;

  always_comb begin
    last_line_d = (({1'b0, line_q} + 1'b1) == num_lines_q);
    adv_line_d  = last_line_d ? line_q : line_q + 1'b1;
    adv_state_d = last_line_d ? (pass2_q ? S_FINISH : S_PASS_SWITCH) : S_LINE_START;
    term_d      = (text_data == 8'h0A) || (text_data == 8'h00) ||
                  (char_q == CW'(CHAR_PER_LINE - 1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      pass2_q      <= 1'b0;
      line_q       <= '0;
      char_q       <= '0;
      char_cnt_q   <= '0;
      wait_q       <= '0;
      num_lines_q  <= '0;
      inst_ptr_q   <= '0;
      full_q       <= 1'b0;
      inst_q       <= '0;
      new_line_q   <= 1'b0;
      new_char_q   <= 1'b0;
      inc_char_q   <= '0;
      asm_q        <= IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_line_q <= '0;
    end else begin
      new_line_q <= 1'b0;
      new_char_q <= 1'b0;
      imem_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_lines != '0) begin
              done_q       <= 1'b0;
              error_q      <= 1'b0;
              error_line_q <= '0;
              busy_q       <= 1'b1;
              pass2_q      <= 1'b0;
              asm_q        <= PC_MAPPING;
              line_q       <= '0;
              inst_ptr_q   <= '0;
              full_q       <= 1'b0;
              num_lines_q  <= num_lines;
              state_q      <= S_LINE_START;
            end else begin
              done_q  <= 1'b1;
              error_q <= 1'b0;
            end
          end
        end
        S_LINE_START: begin
          new_line_q <= 1'b1;
          char_q     <= '0;
          state_q    <= S_FETCH;
        end
        S_FETCH: begin
          wait_q  <= TW'(BRAM_LATENCY - 1);
          state_q <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (wait_q == '0) state_q <= S_EMIT;
          else              wait_q  <= wait_q - 1'b1;
        end
        S_EMIT: begin
          new_char_q <= 1'b1;
          char_cnt_q <= char_q;
          // NUL and unterminated full lines are both handed to the core as a newline
          if (term_d) begin
            inc_char_q <= 8'h0A;
            state_q    <= S_LINE_END;
          end else begin
            inc_char_q <= text_data;
            char_q     <= char_q + 1'b1;
            wait_q     <= TW'(CHAR_GAP - 1);
            state_q    <= S_GAP;
          end
        end
        S_GAP: begin
          if (wait_q == '0) state_q <= S_FETCH;
          else              wait_q  <= wait_q - 1'b1;
        end
        S_LINE_END: begin
          if (pass2_q) begin
            wait_q  <= TW'(DONE_TIMEOUT - 1);
            state_q <= S_WAIT_DONE;
          end else begin
            line_q  <= adv_line_d;
            state_q <= adv_state_d;
          end
        end
        S_WAIT_DONE: begin
          if (core_done) begin
            inst_q  <= core_instruction;
            state_q <= S_WRITE;
          end else if (wait_q == '0) begin
            line_q  <= adv_line_d;
            state_q <= adv_state_d;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        S_WRITE: begin
          if (full_q) begin
            error_q      <= 1'b1;
            error_line_q <= line_q;
            busy_q       <= 1'b0;
            asm_q        <= IDLE;
            state_q      <= S_FAIL;
          end else begin
            imem_we_q   <= 1'b1;
            imem_addr_q <= inst_ptr_q;
            imem_data_q <= inst_q;
            if (inst_ptr_q == LW'(NUMBER_LINES - 1)) full_q     <= 1'b1;
            else                                     inst_ptr_q <= inst_ptr_q + 1'b1;
            line_q  <= adv_line_d;
            state_q <= adv_state_d;
          end
        end
        S_PASS_SWITCH: begin
          // asm_q sat at IDLE for this one cycle so the core clears its PC counters
          asm_q      <= INSTRUCTION_MAPPING;
          pass2_q    <= 1'b1;
          line_q     <= '0;
          inst_ptr_q <= '0;
          full_q     <= 1'b0;
          state_q    <= S_LINE_START;
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          asm_q   <= IDLE;
          state_q <= S_IDLE;
        end
        S_FAIL: begin
          busy_q  <= 1'b0;
          asm_q   <= IDLE;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (state_q == S_LINE_END && !pass2_q && last_line_d) asm_q <= IDLE;

      // core error overrides any same-cycle done or pending write
      if (busy_q && core_error && state_q != S_FINISH && state_q != S_FAIL) begin
        error_q      <= 1'b1;
        error_line_q <= line_q;
        busy_q       <= 1'b0;
        asm_q        <= IDLE;
        imem_we_q    <= 1'b0;
        state_q      <= S_FAIL;
      end
    end
  end

  assign text_addr          = AW'(int'(line_q) * CHAR_PER_LINE + int'(char_q));
  assign new_line           = new_line_q;
  assign new_character      = new_char_q;
  assign line_count         = line_q;
  assign char_count         = char_cnt_q;
  assign incoming_character = inc_char_q;
  assign assembler_state    = asm_q;
  assign imem_we            = imem_we_q;
  assign imem_addr          = imem_addr_q;
  assign imem_data          = imem_data_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign error_line         = error_line_q;
endmodule

// File: tb/tb_assembler_sequencer.sv
// Randomized bench for assembler_sequencer: BRAM and core models plus a line-level
// reference that predicts every character strobe and instruction-memory write.
module tb_assembler_sequencer;
  import assembler_pkg::*;

  localparam int CPL = 64;
  localparam int NL  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  num_lines = '0;
  logic [13:0] text_addr;
  logic [7:0]  text_data;
  logic        new_line, new_character;
  logic [7:0]  line_count;
  logic [5:0]  char_count;
  logic [7:0]  incoming_character;
  assembler_state_t asm_state;
  logic        core_done = 1'b0, core_error = 1'b0;
  logic [31:0] core_instruction = '0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        busy, done, error;
  logic [7:0]  error_line;

  int n_tests = 0;
  int n_fail  = 0;

  assembler_sequencer dut (
    .clk_in(clk), .rst_in(rst_n), .start(start), .num_lines(num_lines),
    .text_addr(text_addr), .text_data(text_data), .new_line(new_line),
    .new_character(new_character), .line_count(line_count), .char_count(char_count),
    .incoming_character(incoming_character), .assembler_state(asm_state),
    .core_done(core_done), .core_error(core_error), .core_instruction(core_instruction),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .busy(busy), .done(done), .error(error), .error_line(error_line)
  );

  always #5 clk = ~clk;

  logic [7:0] text_mem [0:NL*CPL-1];
  logic [7:0] p1, p2;
  always @(posedge clk) begin
    p1 <= text_mem[text_addr];
    p2 <= p1;
  end
  assign text_data = p2;

  bit          resp [0:15];
  logic [31:0] word [0:15];
  int          err_sel = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // core model: answers a pass-2 newline with done (or error on err_sel) after a short delay
  initial begin : core_model
    int ln;
    forever begin
      @(negedge clk);
      if (rst_n && new_character && incoming_character == 8'h0A &&
          asm_state == INSTRUCTION_MAPPING) begin
        ln = int'(line_count);
        if (ln == err_sel) begin
          repeat ($urandom_range(1, 8)) @(negedge clk);
          core_error = 1'b1;
          @(negedge clk);
          core_error = 1'b0;
        end else if (ln < 16 && resp[ln]) begin
          repeat ($urandom_range(1, 12)) @(negedge clk);
          core_instruction = word[ln];
          core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
          core_instruction = $urandom;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] got_s[$], exp_s[$];
  logic [39:0] got_w[$], exp_w[$];
  int last_s = -1, nl_cyc = -1;

  always @(negedge clk) begin
    if (start && !busy) begin
      got_s.delete(); got_w.delete(); last_s = -1; nl_cyc = -1;
    end
    if (new_line) nl_cyc = cyc;
    if (new_character) begin
      if (last_s >= 0) chk("strobe_spacing_ge6", 64'(cyc - last_s >= 6), 1);
      if (char_count == 6'd0) chk("new_line_before_strobe", 64'(nl_cyc >= 0 && nl_cyc < cyc), 1);
      last_s = cyc;
      got_s.push_back({7'b0, asm_state == INSTRUCTION_MAPPING, line_count, 2'b0,
                       char_count, incoming_character});
    end
    if (imem_we) got_w.push_back({imem_addr, imem_data});
  end

  function automatic logic [31:0] pk(input int p, input int ln, input int j, input logic [7:0] c);
    return {7'b0, p[0], ln[7:0], 2'b0, j[5:0], c};
  endfunction

  // reference: characters of a line up to and including its terminator, terminator shown as 0x0A
  task automatic add_line_exp(input int p, input int ln);
    logic [7:0] c;
    for (int j = 0; j < CPL; j++) begin
      c = text_mem[ln*CPL + j];
      if (c == 8'h0A || c == 8'h00 || j == CPL - 1) begin
        exp_s.push_back(pk(p, ln, j, 8'h0A));
        break;
      end
      exp_s.push_back(pk(p, ln, j, c));
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n*CPL; i++) text_mem[i] = 8'($urandom_range(32, 126));
    for (int i = 0; i < 16; i++) begin
      resp[i] = 1'b1;
      word[i] = $urandom;
    end
  endtask

  task automatic put_line(input int ln, input string s);
    for (int j = 0; j < s.len(); j++) text_mem[ln*CPL + j] = s[j];
  endtask

  task automatic rand_line(input int ln);
    int kind, len;
    kind = $urandom_range(0, 9);
    len  = $urandom_range(1, 20);
    if (kind == 0) begin
      text_mem[ln*CPL] = 8'h00;
      resp[ln] = 1'b0;
    end else if (kind != 1) begin
      text_mem[ln*CPL + len] = (kind == 2) ? 8'h00 : 8'h0A;
      resp[ln] = (kind != 3);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_new_char"}, new_character, 0);
    chk({tag, "_new_line"}, new_line, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_asm_state"}, asm_state, IDLE);
    chk({tag, "_line_count"}, line_count, 0);
    chk({tag, "_char_count"}, char_count, 0);
    chk({tag, "_text_addr"}, text_addr, 0);
    chk({tag, "_error_line"}, error_line, 0);
  endtask

  task automatic run_prog(input int n, input int err, input bit glitch);
    int k;
    bit fin;
    err_sel = err;
    exp_s.delete(); exp_w.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < n; i++) begin
        if (p == 1 && err >= 0 && i > err) break;
        add_line_exp(p, i);
      end
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (err >= 0 && i >= err) break;
      if (resp[i]) begin
        exp_w.push_back({8'(k), word[i]});
        k++;
      end
    end

    @(posedge clk); #1 num_lines = 9'(n); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("done_after_start", done, n == 0);
    chk("busy_after_start", busy, n != 0);

    fin = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done || error) begin
        fin = 1'b1;
        break;
      end
      if (glitch && c == 150) begin
        @(posedge clk); #1 num_lines = 9'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; num_lines = 9'(n);
      end
    end
    chk("run_finished", fin, 1);
    repeat (40) @(negedge clk);

    chk("strobe_count", got_s.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) chk("strobe", got_s[i], exp_s[i]);
    chk("write_count", got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) chk("write", got_w[i], exp_w[i]);
    chk("done_end", done, err < 0);
    chk("error_end", error, err >= 0);
    chk("busy_end", busy, 0);
    chk("asm_state_end", asm_state, IDLE);
    if (err >= 0) chk("error_line", error_line, err);
    err_sel = -1;
  endtask

  initial begin : main
    bit hit;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_prog(0, -1, 1'b0);

    fill_random(3);
    put_line(0, "addi x1, x0, 5\n");
    put_line(1, "add x2, x1, x1\n");
    put_line(2, "beq x1, x2, L\n");
    run_prog(3, -1, 1'b0);

    fill_random(3);
    put_line(0, "addi x1, x0, 5\n");
    text_mem[CPL] = 8'h00;
    resp[1] = 1'b0;
    put_line(2, "beq x1, x2, L\n");
    run_prog(3, -1, 1'b1);

    fill_random(2);
    put_line(1, "nop\n");
    run_prog(2, -1, 1'b0);

    fill_random(4);
    put_line(0, "addi x1, x0, 5\n");
    put_line(1, "add x2, x1, x1\n");
    put_line(2, "sub x3, x2, x1\n");
    put_line(3, "beq x1, x2, L\n");
    run_prog(4, 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      fill_random(n);
      for (int i = 0; i < n; i++) rand_line(i);
      run_prog(n, -1, 1'b0);
    end

    fill_random(3);
    put_line(0, "addi x1, x0, 5\n");
    put_line(1, "add x2, x1, x1\n");
    put_line(2, "beq x1, x2, L\n");
    @(posedge clk); #1 num_lines = 9'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (asm_state == INSTRUCTION_MAPPING && line_count == 8'd1) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_pass2", hit, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_cleared("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_prog(3, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
